// File: rtl/chain_tail_if.sv
// chain_tail_if: opcode package and the packet/event bus between chain end, tail stage and host.
package chain_pkg;
  typedef enum logic [2:0] {DEL, ADD, SET, RDC, MSC} opcode_e;
  localparam logic [27:0] UNF = 28'd1;
  localparam logic [27:0] FLL = 28'd2;
endpackage

interface chain_tail_if #(parameter int CW = 16);
  import chain_pkg::*;
  logic wrm, wrs, wmo, ev_valid, ev_ready, conflict, overflow, round_done;
  opcode_e wop;
  logic [27:0] wid, ev_id, conflict_id, overflow_id;
  logic [1:0] ev_kind;
  logic [CW-1:0] unit_count;
  modport master(output wrm, wop, wmo, wid, ev_ready,
                 input wrs, ev_valid, ev_kind, ev_id, conflict, conflict_id,
                 overflow, overflow_id, unit_count, round_done);
  modport slave(input wrm, wop, wmo, wid, ev_ready,
                output wrs, ev_valid, ev_kind, ev_id, conflict, conflict_id,
                overflow, overflow_id, unit_count, round_done);
endinterface

// File: rtl/chain_tail.sv
// chain_tail: end-of-chain sink turning RDC/MSC UNF packets into a buffered event stream plus sticky status.
module chain_tail
  import chain_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CW = 16
) (
  input logic clk,
  input logic rst,
  chain_tail_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  logic [29:0] mem_q [DEPTH];
  logic [AW-1:0] rp_q, rp_d, wp_q, wp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic conf_q, conf_d, ovf_q, ovf_d, rd_q, rd_d;
  logic [27:0] cid_q, cid_d, oid_q, oid_d;
  logic [CW-1:0] uc_q, uc_d;
  logic acc, flush, unit, cfl, round, add, push, pop;
  logic [29:0] wdat;
  // ready depends only on the registered count, never on ev_ready
  assign bus.wrs = !rst && cnt_q != (AW+1)'(DEPTH);
  assign bus.ev_valid = cnt_q != '0;
  assign bus.ev_kind = mem_q[rp_q][29:28];
  assign bus.ev_id = mem_q[rp_q][27:0];
  assign bus.conflict = conf_q;
  assign bus.conflict_id = cid_q;
  assign bus.overflow = ovf_q;
  assign bus.overflow_id = oid_q;
  assign bus.unit_count = uc_q;
  assign bus.round_done = rd_q;
  always_comb begin
    acc = bus.wrm && bus.wrs;
    flush = acc && bus.wop == DEL;
    add = acc && bus.wop == ADD;
    unit = acc && bus.wop == RDC && bus.wmo;
    cfl = acc && bus.wop == RDC && !bus.wmo;
    round = acc && bus.wop == MSC && bus.wid == UNF;
    push = unit || cfl || round;
    pop = bus.ev_valid && bus.ev_ready;
    wdat = round ? {2'd2, 28'd0} : {cfl ? 2'd1 : 2'd0, bus.wid};
    rp_d = flush ? '0 : rp_q + AW'(pop);
    wp_d = flush ? '0 : wp_q + AW'(push);
    cnt_d = flush ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    conf_d = !flush && (conf_q || cfl);
    cid_d = flush ? '0 : (cfl && !conf_q) ? bus.wid : cid_q;
    ovf_d = !flush && (ovf_q || add);
    oid_d = flush ? '0 : (add && !ovf_q) ? bus.wid : oid_q;
    uc_d = flush ? '0 : (unit && uc_q != '1) ? uc_q + CW'(1) : uc_q;
    rd_d = round;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rp_q <= '0;
      wp_q <= '0;
      cnt_q <= '0;
      conf_q <= 1'b0;
      cid_q <= '0;
      ovf_q <= 1'b0;
      oid_q <= '0;
      uc_q <= '0;
      rd_q <= 1'b0;
    end else begin
      if (push) mem_q[wp_q] <= wdat;
      rp_q <= rp_d;
      wp_q <= wp_d;
      cnt_q <= cnt_d;
      conf_q <= conf_d;
      cid_q <= cid_d;
      ovf_q <= ovf_d;
      oid_q <= oid_d;
      uc_q <= uc_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: doc/chain_tail.md
Name: chain_tail

Overview:
- Terminal stage of the clause-node chain. Connects to the read side of the last clause node and consumes every packet that reaches the end of the chain.
- Converts reduction (RDC) and round-end (MSC UNF) packets into a buffered event stream for the host/controller.
- Keeps sticky conflict and overflow status and a unit counter.
- Always acts as a sink: it never forwards packets further.

Parameters:
DEPTH, 16, event FIFO depth; power of two, >= 2
CW, 16, width of unit counter

Ports:
clk  in  1  clock
rst  in  1  reset
wrm  in  1  packet valid from last node (node's rrs)
wrs  out  1  ready to last node (drives node's rrm)
wop  in  opcode  packet opcode (pkg enum: DEL, ADD, SET, RDC, MSC)
wmo  in  1  packet mode bit
wid  in  28  packet id / clause address / MSC code
ev_valid  out  1  event available
ev_ready  in  1  host pops event
ev_kind  out  2  0=UNIT, 1=CONFLICT, 2=ROUND, 3 unused
ev_id  out  28  clause id for UNIT/CONFLICT; 0 for ROUND
conflict  out  1  sticky: an empty clause was reported
conflict_id  out  28  id of first conflict since last clear
overflow  out  1  sticky: ADD packet fell off chain end
overflow_id  out  28  id of first overflowing ADD
unit_count  out  CW  saturating count of UNIT events enqueued
round_done  out  1  one-cycle pulse when ROUND event enqueued

Behaviour:
- Reset is rst, synchronous, active-high; clock is clk.
- Reset values:
  - FIFO empty; ev_valid=0; ev_kind=0; ev_id=0.
  - conflict=0; conflict_id=0; overflow=0; overflow_id=0.
  - unit_count=0; round_done=0.
  - wrs=0 while rst is high.
- wrs = !rst && (fifo_count != DEPTH).
  - Registered count, no combinational path from ev_ready to wrs.
  - wrs gates every opcode, including ones that do not enqueue.
- Accept = wrm && wrs. Action on accept, by wop:
  - DEL: flush FIFO (count, pointers to 0), clear conflict, conflict_id, overflow, overflow_id and unit_count. Nothing enqueued. A pop in the same cycle is discarded; flush wins.
  - ADD: chain full, clause not stored.
    - If overflow=0: set overflow=1 and overflow_id=wid.
    - If overflow=1: ignore.
    - Nothing enqueued.
  - SET: consumed silently.
  - RDC, wmo=1: enqueue {UNIT, wid}; unit_count += 1, saturating at 2^CW-1.
  - RDC, wmo=0: enqueue {CONFLICT, wid}.
    - If conflict=0: set conflict=1 and conflict_id=wid.
    - Later conflicts are still enqueued but do not change conflict_id.
  - MSC, wid==UNF: enqueue {ROUND, 0}; round_done=1 next cycle only.
  - MSC, any other wid (e.g. FLL): consumed silently.
- Event FIFO:
  - Circular buffer of DEPTH entries {kind[1:0], id[27:0]}; read/write pointers of log2(DEPTH) bits wrap naturally; count of log2(DEPTH)+1 bits.
  - Pop = ev_valid && ev_ready.
  - ev_valid = (count != 0). ev_kind/ev_id = entry at the read pointer, driven from registered storage/pointers.
  - Push and pop in the same cycle: count unchanged, both pointers advance, data order preserved.
  - No fall-through: an event accepted at cycle N is visible on ev_valid at N+1 at the earliest.
  - FIFO full: wrs=0, so the last node holds its packet. A pop that cycle frees a slot; wrs rises at N+1.
- round_done: registered, high exactly one cycle after the MSC UNF accept, otherwise 0. Also 0 when the same cycle carries DEL (impossible: one packet per cycle).
- Reset mid-operation: all state returns to reset values on the next edge; events in the FIFO are lost.
- No X propagation: ev_kind/ev_id are don't-care only when ev_valid=0. Storage is reset to 0 so outputs read 0 after reset.

Test Plan:
- Reset then idle → wrs=1 from the first cycle after rst falls; ev_valid=0; all status=0.
- RDC wmo=1 wid=0x000_0005, ev_ready=0 → next cycle ev_valid=1, ev_kind=0, ev_id=5, unit_count=1. Pop → ev_valid=0.
- RDC wmo=0 wid=7, then RDC wmo=0 wid=9 → conflict=1, conflict_id=7. Two CONFLICT events popped in order 7, 9. DEL afterwards → conflict=0, FIFO empty.
- DEPTH=16: 16 RDC units with ev_ready=0 → wrs=0 after the 16th. Hold a 17th packet (wrm=1) while popping one → the 17th is accepted one cycle after the pop. All 17 ids come out in order.
- ADD wid=0x123 then ADD wid=0x456 → overflow=1, overflow_id=0x123, no events. SET and MSC FLL → no events, no status change.
- MSC wid=UNF → round_done high for exactly one cycle; ROUND event with id=0. Simultaneous push/pop with count=1 keeps count=1 and correct order.
